msg_buffer_scheduler: RTL and testbench

- Shares one packet-injection path among N_BUFFERS message_buffer instances.
- Each cycle it arbitrates round-robin among buffers holding a complete packet whose virtual network has a downstream credit.
- It latches the winner's packet and vnet id, presents them to the flit serializer on a valid/ready handshake, and pulses the winner's clear_buffer on acceptance.
- It keeps per-vnet credit counters fed by credit returns from the router.

---
 rtl/msg_buffer_scheduler_if.sv | 51 +++++
 rtl/msg_buffer_scheduler.sv | 155 +++++++++++++++
 tb/tb_msg_buffer_scheduler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/msg_buffer_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : msg_buffer_scheduler_if
// Description : Bundles the message-buffer side and the serializer/router side
//               of msg_buffer_scheduler. The master modport is the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 4
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 8
`endif

interface msg_buffer_scheduler_if #(
  parameter int N_BUFFERS        = 4,
  parameter int N_BITS_BUFFER_ID = 2,
  parameter int N_BITS_VNET_ID   = 2,
  parameter int PKT_WIDTH        = `MAX_PACKET_LENGHT * `FLIT_WIDTH
);
  localparam int N_VNETS = 2 ** N_BITS_VNET_ID;

  // Message-buffer side
  logic [N_BUFFERS-1:0]                buf_valid_i;
  logic [N_BUFFERS*PKT_WIDTH-1:0]      buf_pkt_i;
  logic [N_BUFFERS*N_BITS_VNET_ID-1:0] buf_vnet_id_i;
  logic [N_BUFFERS-1:0]                buf_clear_o;

  // Serializer side
  logic [PKT_WIDTH-1:0]                pkt_o;
  logic [N_BITS_VNET_ID-1:0]           vnet_id_o;
  logic                                pkt_valid_o;
  logic                                pkt_ready_i;

  // Router credit return and status
  logic [N_VNETS-1:0]                  credit_in_i;
  logic [N_BITS_BUFFER_ID-1:0]         grant_id_o;
  logic                                credit_err_o;

  modport master (
    input  buf_valid_i, buf_pkt_i, buf_vnet_id_i, pkt_ready_i, credit_in_i,
    output buf_clear_o, pkt_o, vnet_id_o, pkt_valid_o, grant_id_o, credit_err_o
  );

  modport slave (
    output buf_valid_i, buf_pkt_i, buf_vnet_id_i, pkt_ready_i, credit_in_i,
    input  buf_clear_o, pkt_o, vnet_id_o, pkt_valid_o, grant_id_o, credit_err_o
  );
endinterface

`default_nettype wire

// File: rtl/msg_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : msg_buffer_scheduler
// Description : Round-robin scheduler sharing one packet-injection path among
//               N_BUFFERS message buffers, gated by per-vnet credit counters.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 4
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 8
`endif

module msg_buffer_scheduler #(
  parameter int N_BUFFERS        = 4,
  parameter int N_BITS_BUFFER_ID = 2,
  parameter int N_BITS_VNET_ID   = 2,
  parameter int N_BITS_CREDIT    = 3,
  parameter int MAX_CREDIT       = 4,
  parameter int PKT_WIDTH        = `MAX_PACKET_LENGHT * `FLIT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  msg_buffer_scheduler_if.master bus
);
  localparam int N_VNETS = 2 ** N_BITS_VNET_ID;
  localparam logic [N_BITS_CREDIT-1:0]    MAX_CNT = N_BITS_CREDIT'(MAX_CREDIT);
  localparam logic [N_BITS_BUFFER_ID-1:0] LAST_ID = N_BITS_BUFFER_ID'(N_BUFFERS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                      state;
  logic [N_BITS_BUFFER_ID-1:0] rr_ptr;
  logic [N_BITS_CREDIT-1:0]    credit     [N_VNETS];
  logic [N_BITS_CREDIT-1:0]    credit_nxt [N_VNETS];
  logic [N_VNETS-1:0]          credit_ovf;

  logic [N_BITS_VNET_ID-1:0]   buf_vnet [N_BUFFERS];
  logic [PKT_WIDTH-1:0]        buf_pkt  [N_BUFFERS];
  logic [N_BUFFERS-1:0]        eligible;
  logic [2*N_BUFFERS-1:0]      elig_rot;

  logic                        found;
  logic [N_BITS_BUFFER_ID-1:0] win_id;
  logic                        grant;
  logic                        accept;

  // Unpack the flat buffer buses and decide which buffers may be granted.
  for (genvar k = 0; k < N_BUFFERS; k++) begin : g_unpack
    assign buf_vnet[k] = bus.buf_vnet_id_i[k*N_BITS_VNET_ID +: N_BITS_VNET_ID];
    assign buf_pkt[k]  = bus.buf_pkt_i[k*PKT_WIDTH +: PKT_WIDTH];
    assign eligible[k] = bus.buf_valid_i[k] && (credit[buf_vnet[k]] != '0);
  end

  // Round-robin search: rotate the request vector so rr_ptr sits at bit 0,
  // take the lowest set bit, then map its offset back to a buffer index.
  always_comb begin
    int sum;
    sum      = 0;
    found    = 1'b0;
    win_id   = '0;
    elig_rot = {eligible, eligible} >> rr_ptr;
    for (int i = 0; i < N_BUFFERS; i++) begin
      if (!found && elig_rot[i]) begin
        found = 1'b1;
        sum   = int'(rr_ptr) + i;
        if (sum >= N_BUFFERS) sum = sum - N_BUFFERS;
        win_id = sum[N_BITS_BUFFER_ID-1:0];
      end
    end
  end

  assign grant  = (state == IDLE) && found;
  assign accept = bus.pkt_valid_o && bus.pkt_ready_i;

  // One-hot clear to the granted buffer, only in the cycle the packet is taken.
  always_comb begin
    bus.buf_clear_o = '0;
    if (accept) bus.buf_clear_o[bus.grant_id_o] = 1'b1;
  end

  // Next credit value per vnet: a grant and a return in the same cycle cancel;
  // a return with the counter already full is flagged and otherwise dropped.
  always_comb begin
    for (int v = 0; v < N_VNETS; v++) begin
      logic dec;
      logic inc;
      dec           = grant && (buf_vnet[win_id] == N_BITS_VNET_ID'(v));
      inc           = bus.credit_in_i[v];
      credit_nxt[v] = credit[v];
      credit_ovf[v] = 1'b0;
      if (dec && !inc) begin
        credit_nxt[v] = credit[v] - 1'b1;
      end else if (inc && !dec) begin
        if (credit[v] == MAX_CNT) credit_ovf[v] = 1'b1;
        else                      credit_nxt[v] = credit[v] + 1'b1;
      end
    end
  end

  // Credit counters and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < N_VNETS; v++) credit[v] <= MAX_CNT;
      bus.credit_err_o <= 1'b0;
    end else begin
      for (int v = 0; v < N_VNETS; v++) credit[v] <= credit_nxt[v];
      if (|credit_ovf) bus.credit_err_o <= 1'b1;
    end
  end

  // Grant FSM: latch the winner in IDLE, hold it in SEND until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      bus.pkt_valid_o <= 1'b0;
      bus.pkt_o       <= '0;
      bus.vnet_id_o   <= '0;
      bus.grant_id_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            bus.pkt_o       <= buf_pkt[win_id];
            bus.vnet_id_o   <= buf_vnet[win_id];
            bus.grant_id_o  <= win_id;
            bus.pkt_valid_o <= 1'b1;
            state           <= SEND;
          end else begin
            bus.pkt_valid_o <= 1'b0;
          end
        end
        SEND: begin
          if (bus.pkt_ready_i) begin
            bus.pkt_valid_o <= 1'b0;
            rr_ptr          <= (bus.grant_id_o == LAST_ID) ? '0
                                                           : bus.grant_id_o + 1'b1;
            state           <= IDLE;
          end
        end
        default: begin
          bus.pkt_valid_o <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_msg_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_msg_buffer_scheduler
// Description : Table-driven directed bench for msg_buffer_scheduler plus
//               hand-written credit-exhaustion and async-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msg_buffer_scheduler;
  localparam logic [31:0] K1 = 32'h11111111;
  localparam logic [31:0] K2 = 32'h22222222;
  localparam logic [31:0] K3 = 32'h33333333;
  localparam logic [31:0] K4 = 32'h44444444;
  localparam logic [127:0] P0 = {K4, K3, K2, K1};
  localparam logic [127:0] PB = {K4, K3, 32'hDEADBEEF, K1};
  localparam logic [127:0] PC = {K4, K3, 32'h12345678, K1};
  localparam logic [127:0] PD = {K4, K3, 32'hCAFEF00D, K1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  msg_buffer_scheduler_if #(.N_BUFFERS(4), .N_BITS_BUFFER_ID(2), .N_BITS_VNET_ID(2),
                            .PKT_WIDTH(32)) bus ();

  msg_buffer_scheduler #(.N_BUFFERS(4), .N_BITS_BUFFER_ID(2), .N_BITS_VNET_ID(2),
                         .N_BITS_CREDIT(3), .MAX_CREDIT(4), .PKT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string        name;
    logic [3:0]   valid;
    logic [7:0]   vnets;
    logic [127:0] pkts;
    logic         ready;
    logic [3:0]   cin;
    logic         epv;
    logic [1:0]   egid;
    logic [1:0]   evn;
    logic [31:0]  epkt;
    logic [3:0]   eclr;
    logic         eerr;
    logic [15:0]  ecred;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_g3;

  function automatic vec_t mk(string nm, logic [3:0] v, logic [7:0] vn, logic [127:0] pk,
                              logic rdy, logic [3:0] ci, logic pv, logic [1:0] gid,
                              logic [1:0] evn, logic [31:0] ep, logic [3:0] clr,
                              logic err, logic [15:0] cr);
    vec_t t;
    t.name = nm; t.valid = v; t.vnets = vn; t.pkts = pk; t.ready = rdy; t.cin = ci;
    t.epv = pv; t.egid = gid; t.evn = evn; t.epkt = ep; t.eclr = clr; t.eerr = err;
    t.ecred = cr;
    return t;
  endfunction

  // Credit counters as nibbles {c3,c2,c1,c0}.
  function automatic logic [15:0] credits();
    return {1'b0, dut.credit[3], 1'b0, dut.credit[2], 1'b0, dut.credit[1], 1'b0, dut.credit[0]};
  endfunction

  task automatic drive(input logic [3:0] v, input logic [7:0] vn, input logic [127:0] pk,
                       input logic rdy, input logic [3:0] ci);
    @(negedge clk);
    bus.buf_valid_i   = v;
    bus.buf_vnet_id_i = vn;
    bus.buf_pkt_i     = pk;
    bus.pkt_ready_i   = rdy;
    bus.credit_in_i   = ci;
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.buf_valid_i = '0; bus.buf_vnet_id_i = '0; bus.buf_pkt_i = '0;
    bus.pkt_ready_i = 1'b0; bus.credit_in_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state, then round-robin over four vnet-0 buffers with a credit
    // returned in every grant cycle so vnet 0 never drains.
    vq.push_back(mk("reset",   4'h0, 8'h00, P0, 1, 4'h0, 0, 0, 0, 32'h0, 4'h0, 0, 16'h4444));
    vq.push_back(mk("rr_g0",   4'hF, 8'h00, P0, 1, 4'h1, 0, 0, 0, 32'h0, 4'h0, 0, 16'h4444));
    vq.push_back(mk("rr_s0",   4'hF, 8'h00, P0, 1, 4'h0, 1, 0, 0, K1,    4'h1, 0, 16'h4444));
    vq.push_back(mk("rr_g1",   4'hE, 8'h00, P0, 1, 4'h1, 0, 0, 0, K1,    4'h0, 0, 16'h4444));
    vq.push_back(mk("rr_s1",   4'hF, 8'h00, P0, 1, 4'h0, 1, 1, 0, K2,    4'h2, 0, 16'h4444));
    vq.push_back(mk("rr_g2",   4'hD, 8'h00, P0, 1, 4'h1, 0, 1, 0, K2,    4'h0, 0, 16'h4444));
    vq.push_back(mk("rr_s2",   4'hF, 8'h00, P0, 1, 4'h0, 1, 2, 0, K3,    4'h4, 0, 16'h4444));
    vq.push_back(mk("rr_g3",   4'hB, 8'h00, P0, 1, 4'h1, 0, 2, 0, K3,    4'h0, 0, 16'h4444));
    vq.push_back(mk("rr_s3",   4'hF, 8'h00, P0, 1, 4'h0, 1, 3, 0, K4,    4'h8, 0, 16'h4444));
    vq.push_back(mk("rr_g0b",  4'h7, 8'h00, P0, 1, 4'h1, 0, 3, 0, K4,    4'h0, 0, 16'h4444));
    vq.push_back(mk("rr_s0b",  4'hF, 8'h00, P0, 1, 4'h0, 1, 0, 0, K1,    4'h1, 0, 16'h4444));
    vq.push_back(mk("rr_end",  4'h0, 8'h00, P0, 1, 4'h0, 0, 0, 0, K1,    4'h0, 0, 16'h4444));
    // Single request: buffer 2 on vnet 1.
    vq.push_back(mk("sr_req",  4'h4, 8'h10, P0, 1, 4'h0, 0, 0, 0, K1,    4'h0, 0, 16'h4444));
    vq.push_back(mk("sr_send", 4'h4, 8'h10, P0, 1, 4'h0, 1, 2, 1, K3,    4'h4, 0, 16'h4434));
    vq.push_back(mk("sr_done", 4'h0, 8'h10, P0, 1, 4'h0, 0, 2, 1, K3,    4'h0, 0, 16'h4434));
    // Backpressure on buffer 1 while its input packet keeps changing.
    vq.push_back(mk("bp_req",  4'h2, 8'h00, P0, 0, 4'h0, 0, 2, 1, K3,    4'h0, 0, 16'h4434));
    vq.push_back(mk("bp_w1",   4'h2, 8'h00, PB, 0, 4'h0, 1, 1, 0, K2,    4'h0, 0, 16'h4433));
    vq.push_back(mk("bp_w2",   4'hF, 8'h00, PC, 0, 4'h0, 1, 1, 0, K2,    4'h0, 0, 16'h4433));
    vq.push_back(mk("bp_w3",   4'hF, 8'h00, PD, 0, 4'h0, 1, 1, 0, K2,    4'h0, 0, 16'h4433));
    vq.push_back(mk("bp_w4",   4'h2, 8'h00, PB, 0, 4'h0, 1, 1, 0, K2,    4'h0, 0, 16'h4433));
    vq.push_back(mk("bp_w5",   4'h2, 8'h00, PC, 0, 4'h0, 1, 1, 0, K2,    4'h0, 0, 16'h4433));
    vq.push_back(mk("bp_acc",  4'h2, 8'h00, PC, 1, 4'h0, 1, 1, 0, K2,    4'h2, 0, 16'h4433));
    vq.push_back(mk("bp_done", 4'h0, 8'h00, P0, 1, 4'h0, 0, 1, 0, K2,    4'h0, 0, 16'h4433));
    // Return on a full counter (vnet 3) sets the sticky error; refill vnets 0/1.
    vq.push_back(mk("er_ret",  4'h0, 8'h00, P0, 1, 4'h8, 0, 1, 0, K2,    4'h0, 0, 16'h4433));
    vq.push_back(mk("er_fix",  4'h0, 8'h00, P0, 1, 4'h3, 0, 1, 0, K2,    4'h0, 1, 16'h4433));
    vq.push_back(mk("er_hold", 4'h0, 8'h00, P0, 1, 4'h0, 0, 1, 0, K2,    4'h0, 1, 16'h4444));
    // Drain vnet 2 to 2, then grant and return together: stays at 2.
    vq.push_back(mk("sg_a1",   4'h4, 8'h20, P0, 1, 4'h0, 0, 1, 0, K2,    4'h0, 1, 16'h4444));
    vq.push_back(mk("sg_a2",   4'h4, 8'h20, P0, 1, 4'h0, 1, 2, 2, K3,    4'h4, 1, 16'h4344));
    vq.push_back(mk("sg_a3",   4'h0, 8'h20, P0, 1, 4'h0, 0, 2, 2, K3,    4'h0, 1, 16'h4344));
    vq.push_back(mk("sg_b1",   4'h4, 8'h20, P0, 1, 4'h0, 0, 2, 2, K3,    4'h0, 1, 16'h4344));
    vq.push_back(mk("sg_b2",   4'h4, 8'h20, P0, 1, 4'h0, 1, 2, 2, K3,    4'h4, 1, 16'h4244));
    vq.push_back(mk("sg_b3",   4'h0, 8'h20, P0, 1, 4'h0, 0, 2, 2, K3,    4'h0, 1, 16'h4244));
    vq.push_back(mk("sg_c1",   4'h4, 8'h20, P0, 1, 4'h4, 0, 2, 2, K3,    4'h0, 1, 16'h4244));
    vq.push_back(mk("sg_c2",   4'h4, 8'h20, P0, 1, 4'h0, 1, 2, 2, K3,    4'h4, 1, 16'h4244));
    vq.push_back(mk("sg_r1",   4'h0, 8'h20, P0, 1, 4'h4, 0, 2, 2, K3,    4'h0, 1, 16'h4244));
    vq.push_back(mk("sg_r2",   4'h0, 8'h20, P0, 1, 4'h4, 0, 2, 2, K3,    4'h0, 1, 16'h4344));
    vq.push_back(mk("sg_r3",   4'h0, 8'h20, P0, 1, 4'h0, 0, 2, 2, K3,    4'h0, 1, 16'h4444));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].valid, vq[i].vnets, vq[i].pkts, vq[i].ready, vq[i].cin);
      check(vq[i].name,
            {6'b0, bus.pkt_valid_o, bus.grant_id_o, bus.vnet_id_o, bus.pkt_o,
             bus.buf_clear_o, bus.credit_err_o, credits()},
            {6'b0, vq[i].epv, vq[i].egid, vq[i].evn, vq[i].epkt,
             vq[i].eclr, vq[i].eerr, vq[i].ecred});
    end

    // Credit exhaustion: four grants of buffer 3 on vnet 3 with no returns.
    n_g3 = 0;
    for (int i = 0; i < 8; i++) begin
      drive(4'h8, 8'hC0, P0, 1, 4'h0);
      if (bus.pkt_valid_o && bus.grant_id_o == 2'd3 && bus.buf_clear_o == 4'h8) n_g3++;
    end
    check("ex_count", 64'(n_g3), 64'd4);
    check("ex_cred0", 64'(credits()), 64'h0444);
    // Buffer 1 (vnet 3, no credit) must be skipped in favour of buffer 2 (vnet 0).
    drive(4'h6, 8'h0C, P0, 0, 4'h0);
    check("ex_idle", 64'(bus.pkt_valid_o), 64'd0);
    drive(4'h6, 8'h0C, P0, 1, 4'h0);
    check("ex_skip", {57'b0, bus.pkt_valid_o, bus.grant_id_o, bus.buf_clear_o},
          {57'b0, 1'b1, 2'd2, 4'h4});
    drive(4'h2, 8'h0C, P0, 1, 4'h8);
    check("ex_nocred", 64'(bus.pkt_valid_o), 64'd0);
    drive(4'h2, 8'h0C, P0, 1, 4'h0);
    check("ex_ret", {47'b0, bus.pkt_valid_o, credits()}, {47'b0, 1'b0, 16'h1443});
    drive(4'h2, 8'h0C, P0, 1, 4'h0);
    check("ex_grant3",
          {23'b0, bus.pkt_valid_o, bus.grant_id_o, bus.vnet_id_o, bus.pkt_o, bus.buf_clear_o},
          {23'b0, 1'b1, 2'd1, 2'd3, K2, 4'h2});
    drive(4'h0, 8'h0C, P0, 1, 4'h0);
    check("ex_cred1", 64'(credits()), 64'h0443);

    // Asynchronous reset in the middle of a SEND with ready raised.
    drive(4'h1, 8'h00, P0, 0, 4'h0);
    drive(4'h1, 8'h00, P0, 0, 4'h0);
    check("rs_send", {45'b0, bus.pkt_valid_o, bus.grant_id_o, credits()},
          {45'b0, 1'b1, 2'd0, 16'h0442});
    #2;
    rst = 1'b1;
    bus.pkt_ready_i = 1'b1;
    #1;
    check("rs_async",
          {40'b0, bus.pkt_valid_o, bus.buf_clear_o, bus.credit_err_o, credits(), dut.rr_ptr},
          {40'b0, 1'b0, 4'h0, 1'b0, 16'h4444, 2'd0});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rs_rel", {59'b0, bus.pkt_valid_o, bus.buf_clear_o}, 64'd0);
    drive(4'h1, 8'h00, P0, 1, 4'h0);
    check("rs_regrant",
          {25'b0, bus.pkt_valid_o, bus.grant_id_o, bus.pkt_o, bus.buf_clear_o},
          {25'b0, 1'b1, 2'd0, K1, 4'h1});
    drive(4'h0, 8'h00, P0, 1, 4'h0);
    check("rs_cred", {47'b0, bus.pkt_valid_o, credits()}, {47'b0, 1'b0, 16'h4443});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
